// File: rtl/serial_subtractor_16_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// borrow_out is present only when SUB_BORROW_OUT_EN is defined.
interface serial_subtractor_16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
`ifdef SUB_BORROW_OUT_EN
  logic             borrow_out;
`endif

  // master: operand producer / result consumer side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff
`ifdef SUB_BORROW_OUT_EN
    , input borrow_out
`endif
  );

  // slave: the subtractor itself
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff
`ifdef SUB_BORROW_OUT_EN
    , output borrow_out
`endif
  );
endinterface

// File: rtl/serial_subtractor_16.sv
// Bit-serial a-b, LSB first, one borrow cell; out_valid WIDTH clocks after accept, held under unbounded backpressure.
// SUB_BORROW_OUT_EN adds the final borrow (a < b unsigned) as borrow_out.
module serial_subtractor_16 #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_subtractor_16_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_diff;
  logic             bit_borrow;
`ifdef SUB_BORROW_OUT_EN
  logic             borrow_out_q, borrow_out_d;
`endif

  // Single full-subtractor cell fed from the LSBs of the operand shifters
  assign bit_diff   = sh_a_q[0] ^ sh_b_q[0] ^ borrow_q;
  assign bit_borrow = (~sh_a_q[0] & sh_b_q[0]) | (~(sh_a_q[0] ^ sh_b_q[0]) & borrow_q);

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef SUB_BORROW_OUT_EN
    borrow_out_d = borrow_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_a_d   = bus.a;
          sh_b_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
        res_d    = {bit_diff, res_q[WIDTH-1:1]};
        borrow_d = bit_borrow;
        cnt_d    = cnt_q + CW'(1);
        // diff only moves on the last step so consumers never see a partial shift
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {bit_diff, res_q[WIDTH-1:1]};
`ifdef SUB_BORROW_OUT_EN
          borrow_out_d = bit_borrow;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SUB_BORROW_OUT_EN
      borrow_out_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef SUB_BORROW_OUT_EN
      borrow_out_q <= borrow_out_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
`ifdef SUB_BORROW_OUT_EN
  assign bus.borrow_out = borrow_out_q;
`endif

endmodule
